rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 8-way resource among eight requesters.
- Drives a one-hot grant vector through a fully specified 3-to-8 decode, plus the encoded winner index.
- Sits between the requester blocks and the shared resource; downstream logic uses gnt_idx as the resource select.
- Bounds grant tenure with a hold limit so no single requester can starve the others.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one tenure may last; 0 = unlimited.
- CNT_W, 8: hold-counter width; MAX_HOLD must be < 2**CNT_W (elaboration-time check).

Ports:
- sys_clk  input  1  system clock; all state changes on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the resource; level-sensitive.
- gnt  output  8  one-hot grant; all zero when no grant.
- gnt_idx  output  3  encoded index of the current or most recent winner.
- gnt_vld  output  1  a grant is active.
- gnt_start  output  1  one-cycle pulse on the first cycle of each new tenure.
- timeout  output  1  one-cycle pulse on the first cycle after a forced (MAX_HOLD) release.

Behaviour:
- All outputs are registered. States are IDLE and GRANT.
- Reset (sync, any state, including mid-tenure):
  - gnt=0, gnt_idx=0, gnt_vld=0, gnt_start=0, timeout=0.
  - hold_cnt=0, last pointer=7, state=IDLE.
  - Requester 0 has highest priority after reset.
- Arbitration function:
  - Search req starting at (last+1) mod 8, ascending with wrap 7→0.
  - The first set bit wins. last is updated to the winner when the grant is issued.
- IDLE:
  - If req != 0: next cycle go to GRANT with gnt_idx=winner, gnt=1<<winner, gnt_vld=1, gnt_start=1, hold_cnt=1.
  - Latency is one cycle from req sampled to gnt visible.
  - Otherwise stay in IDLE with outputs at zero.
- GRANT, evaluated each cycle on the registered gnt_idx:
  - Voluntary release (req[gnt_idx]=0):
    - Arbitrate over req with the current bit masked.
    - If a winner exists, grant it next cycle with no idle bubble: gnt_start=1, hold_cnt=1, timeout=0.
    - If no winner, go to IDLE: gnt=0, gnt_vld=0 next cycle; gnt_idx keeps its value.
  - Forced release (req[gnt_idx]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD):
    - Arbitrate with the current bit masked and grant the winner next cycle with timeout=1, gnt_start=1.
    - If no other requester exists, re-grant the same requester as a new tenure: gnt unchanged, gnt_start=1, timeout=1, hold_cnt=1.
  - Otherwise: hold the grant and increment hold_cnt. With MAX_HOLD=0 the counter saturates at 2**CNT_W-1.
- Simultaneous events: a voluntary release in the same cycle hold_cnt reaches MAX_HOLD counts as voluntary, so timeout=0.
- gnt_start and timeout are high for exactly one cycle per event. They self-clear the next cycle unless a new event occurs.
- Invariants, checked every cycle:
  - gnt == (gnt_vld ? 1<<gnt_idx : 0).
  - popcount(gnt) <= 1.
  - No X on any output after reset.
- The decode from gnt_idx to gnt covers all 8 codes plus a default. No latch may be inferred anywhere; every combinational branch assigns every signal.
- Requests that rise and fall while another requester holds the grant are not remembered (no queuing).

Test Plan:
- Basic grant: reset, then req=8'b0000_0001 → next cycle gnt=8'b0000_0001, gnt_idx=0, gnt_vld=1, gnt_start=1 for 1 cycle. Drop req → next cycle gnt=0, gnt_vld=0, gnt_idx=0.
- Full rotation: MAX_HOLD=4, req=8'hFF held → grants 0,1,…,7,0 each lasting 4 cycles. timeout=1 and gnt_start=1 on the first cycle of each tenure after the first; wrap 7→0 verified.
- Back-to-back release: req=8'b0000_0110, gnt=8'b0000_0010. Clear bit1 → next cycle gnt=8'b0000_0100, gnt_start=1, timeout=0, gnt_vld never low.
- Single-requester timeout: MAX_HOLD=4, req=8'b0001_0000 held 12 cycles → gnt constant 8'b0001_0000. gnt_start and timeout pulse at cycles 5 and 9 of the grant.
- Reset mid-tenure: grant held on idx 5, sys_rst=1 for one cycle with req=8'hFF still set.
  - Cycle after the reset edge: all outputs 0.
  - Next cycle: gnt=8'b0000_0001, confirming the pointer reset to 7.
- Random soak: 10k cycles of random req with MAX_HOLD in {0,3,16} → invariants always hold. Every persistently asserted requester is granted within 8*MAX_HOLD+8 cycles when MAX_HOLD!=0.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter over eight requesters with hold-limited tenure and one-hot plus encoded grant.
// One cycle from sampled req to visible grant; no backpressure beyond the level-sensitive req vector.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       gnt_start,
  output logic       timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               HOLD_EN  = (MAX_HOLD != 0);

  generate
    if (MAX_HOLD >= 2**CNT_W) begin : g_bad_hold
      $error("rr_arbiter_8: MAX_HOLD must be below 2**CNT_W");
    end
  endgenerate

  function automatic logic [7:0] dec8(input logic [2:0] idx);
    case (idx)
      3'd0:    dec8 = 8'b0000_0001;
      3'd1:    dec8 = 8'b0000_0010;
      3'd2:    dec8 = 8'b0000_0100;
      3'd3:    dec8 = 8'b0000_1000;
      3'd4:    dec8 = 8'b0001_0000;
      3'd5:    dec8 = 8'b0010_0000;
      3'd6:    dec8 = 8'b0100_0000;
      3'd7:    dec8 = 8'b1000_0000;
      default: dec8 = 8'b0000_0000;
    endcase
  endfunction

  state_t           r_state, w_nxt_state;
  logic [2:0]       r_last, w_nxt_last;
  logic [2:0]       r_gnt_idx, w_nxt_idx;
  logic [7:0]       r_gnt;
  logic             r_gnt_vld, w_nxt_vld;
  logic             r_gnt_start, w_nxt_start;
  logic             r_timeout, w_nxt_to;
  logic [CNT_W-1:0] r_hold_cnt, w_nxt_cnt;

  logic [7:0] w_arb_req;
  logic [2:0] w_ptr, w_cand, w_win_idx;
  logic       w_win_vld, w_cur_req;

  // While granted, the holder's own bit is masked so any transfer goes to someone else.
  assign w_arb_req = (r_state == S_GRANT) ? (req & ~dec8(r_gnt_idx)) : req;
  assign w_cur_req = req[r_gnt_idx];
  assign w_ptr     = r_last + 3'd1;

  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = 3'd0;
    w_cand    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w_cand = w_ptr + 3'(k);
      if (!w_win_vld && w_arb_req[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_last  = r_last;
    w_nxt_idx   = r_gnt_idx;
    w_nxt_vld   = r_gnt_vld;
    w_nxt_start = 1'b0;
    w_nxt_to    = 1'b0;
    w_nxt_cnt   = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        w_nxt_vld = 1'b0;
        if (w_win_vld) begin
          w_nxt_state = S_GRANT;
          w_nxt_idx   = w_win_idx;
          w_nxt_last  = w_win_idx;
          w_nxt_vld   = 1'b1;
          w_nxt_start = 1'b1;
          w_nxt_cnt   = CNT_ONE;
        end
      end
      S_GRANT: begin
        if (!w_cur_req) begin
          if (w_win_vld) begin
            w_nxt_idx   = w_win_idx;
            w_nxt_last  = w_win_idx;
            w_nxt_start = 1'b1;
            w_nxt_cnt   = CNT_ONE;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_vld   = 1'b0;
            w_nxt_cnt   = '0;
          end
        end else if (HOLD_EN && (r_hold_cnt == HOLD_LIM)) begin
          // Forced release; with no competitor the holder starts a fresh tenure.
          w_nxt_start = 1'b1;
          w_nxt_to    = 1'b1;
          w_nxt_cnt   = CNT_ONE;
          if (w_win_vld) begin
            w_nxt_idx  = w_win_idx;
            w_nxt_last = w_win_idx;
          end
        end else if (r_hold_cnt != '1) begin
          w_nxt_cnt = r_hold_cnt + CNT_ONE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_last      <= 3'd7;
      r_gnt_idx   <= 3'd0;
      r_gnt       <= 8'h00;
      r_gnt_vld   <= 1'b0;
      r_gnt_start <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_last      <= w_nxt_last;
      r_gnt_idx   <= w_nxt_idx;
      r_gnt       <= w_nxt_vld ? dec8(w_nxt_idx) : 8'h00;
      r_gnt_vld   <= w_nxt_vld;
      r_gnt_start <= w_nxt_start;
      r_timeout   <= w_nxt_to;
      r_hold_cnt  <= w_nxt_cnt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_vld   = r_gnt_vld;
  assign gnt_start = r_gnt_start;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed-vector bench for rr_arbiter_8: a limited-hold instance and an unlimited-hold instance.
module tb_rr_arbiter_8;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       start;
    logic       to;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst, sys_rst_u;
  logic [7:0] req, req_u;
  logic [7:0] gnt, gnt_u;
  logic [2:0] gnt_idx, gnt_idx_u;
  logic       gnt_vld, gnt_vld_u, gnt_start, gnt_start_u, timeout, timeout_u;

  exp_t q_lim[$];
  exp_t q_nol[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   armed  = 1'b0;

  rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(8)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld),
    .gnt_start(gnt_start), .timeout(timeout)
  );

  rr_arbiter_8 #(.MAX_HOLD(0), .CNT_W(2)) u_dut_nolim (
    .sys_clk(sys_clk), .sys_rst(sys_rst_u), .req(req_u),
    .gnt(gnt_u), .gnt_idx(gnt_idx_u), .gnt_vld(gnt_vld_u),
    .gnt_start(gnt_start_u), .timeout(timeout_u)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Drive one cycle of stimulus and queue the outputs expected after the next rising edge.
  task automatic vec(input bit on_u, input string tag, input logic rst, input logic [7:0] r,
                     input int idx, input logic vld, input logic st, input logic to);
    exp_t e;
    @(negedge sys_clk);
    if (on_u) begin
      sys_rst_u = rst;
      req_u     = r;
    end else begin
      sys_rst = rst;
      req     = r;
    end
    e.tag   = tag;
    e.idx   = 3'(idx);
    e.vld   = vld;
    e.start = st;
    e.to    = to;
    e.gnt   = vld ? (8'b1 << idx) : 8'h00;
    if (on_u) q_nol.push_back(e);
    else      q_lim.push_back(e);
  endtask

  task automatic compare(input string who, input exp_t e, input logic [7:0] g, input logic [2:0] i,
                         input logic v, input logic s, input logic t);
    n_vec++;
    if (g !== e.gnt || i !== e.idx || v !== e.vld || s !== e.start || t !== e.to) begin
      n_miss++;
      $display("FAIL %s/%s @%0t: got gnt=%b idx=%0d vld=%b start=%b to=%b, want gnt=%b idx=%0d vld=%b start=%b to=%b",
               who, e.tag, $time, g, i, v, s, t, e.gnt, e.idx, e.vld, e.start, e.to);
    end
  endtask

  task automatic invariants(input string who, input logic [7:0] g, input logic [2:0] i,
                            input logic v, input logic s, input logic t);
    logic [7:0] want;
    want = v ? (8'b1 << i) : 8'h00;
    if ($isunknown({g, i, v, s, t}) || g !== want || $countones(g) > 1) begin
      n_miss++;
      $display("FAIL %s/invariant @%0t: got gnt=%b idx=%0d vld=%b, want gnt=%b one-hot and no X",
               who, $time, g, i, v, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (q_lim.size() > 0) begin
        e = q_lim.pop_front();
        compare("lim", e, gnt, gnt_idx, gnt_vld, gnt_start, timeout);
        armed = 1'b1;
      end
      if (q_nol.size() > 0) begin
        e = q_nol.pop_front();
        compare("nolim", e, gnt_u, gnt_idx_u, gnt_vld_u, gnt_start_u, timeout_u);
      end
      if (armed) begin
        invariants("lim", gnt, gnt_idx, gnt_vld, gnt_start, timeout);
        invariants("nolim", gnt_u, gnt_idx_u, gnt_vld_u, gnt_start_u, timeout_u);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation exceeded time bound, queues lim=%0d nolim=%0d",
             q_lim.size(), q_nol.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    sys_rst   = 1'b1;
    sys_rst_u = 1'b1;
    req       = 8'h00;
    req_u     = 8'h00;

    vec(0, "reset", 1, 8'h00, 0, 0, 0, 0);
    vec(0, "reset", 1, 8'h00, 0, 0, 0, 0);

    vec(0, "basic_grant", 0, 8'h01, 0, 1, 1, 0);
    vec(0, "basic_hold",  0, 8'h01, 0, 1, 0, 0);
    vec(0, "basic_drop",  0, 8'h00, 0, 0, 0, 0);
    vec(0, "basic_idle",  0, 8'h00, 0, 0, 0, 0);

    // Full rotation 0..7 then wrap to 0, four cycles per tenure.
    vec(0, "rot_reset", 1, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      for (int c = 0; c < 4; c++)
        vec(0, "rotate", 0, 8'hFF, k % 8, 1, c == 0, (c == 0) && (k > 0));

    vec(0, "b2b_reset",  1, 8'h00, 0, 0, 0, 0);
    vec(0, "b2b_grant",  0, 8'h06, 1, 1, 1, 0);
    vec(0, "b2b_hold",   0, 8'h06, 1, 1, 0, 0);
    vec(0, "b2b_switch", 0, 8'h04, 2, 1, 1, 0);
    vec(0, "b2b_hold2",  0, 8'h04, 2, 1, 0, 0);
    vec(0, "b2b_rel",    0, 8'h00, 2, 0, 0, 0);
    vec(0, "idx_keep",   0, 8'h00, 2, 0, 0, 0);

    // Release coinciding with the hold limit is voluntary: no timeout.
    vec(0, "sim_grant", 0, 8'h18, 3, 1, 1, 0);
    for (int c = 0; c < 3; c++)
      vec(0, "sim_hold", 0, 8'h18, 3, 1, 0, 0);
    vec(0, "sim_vol", 0, 8'h10, 4, 1, 1, 0);

    for (int c = 2; c <= 12; c++)
      vec(0, "single_to", 0, 8'h10, 4, 1, (c == 5) || (c == 9), (c == 5) || (c == 9));

    vec(0, "to_idx5",  0, 8'h20, 5, 1, 1, 0);
    vec(0, "hold5",    0, 8'hFF, 5, 1, 0, 0);
    vec(0, "rst_mid",  1, 8'hFF, 0, 0, 0, 0);
    vec(0, "post_rst", 0, 8'hFF, 0, 1, 1, 0);

    // A request that comes and goes during another tenure is forgotten.
    vec(0, "noq_hold",  0, 8'h09, 0, 1, 0, 0);
    vec(0, "noq_drop3", 0, 8'h01, 0, 1, 0, 0);
    vec(0, "noq_rel",   0, 8'h00, 0, 0, 0, 0);

    // Unlimited hold with a 2-bit counter: saturates, never forces a release.
    vec(1, "nl_reset", 1, 8'h00, 0, 0, 0, 0);
    vec(1, "nl_grant", 0, 8'h01, 0, 1, 1, 0);
    for (int c = 0; c < 12; c++)
      vec(1, "nl_hold", 0, 8'h01, 0, 1, 0, 0);
    vec(1, "nl_contend", 0, 8'h03, 0, 1, 0, 0);
    vec(1, "nl_switch",  0, 8'h02, 1, 1, 1, 0);
    vec(1, "nl_rel",     0, 8'h00, 1, 0, 0, 0);

    repeat (3) @(negedge sys_clk);
    if (q_lim.size() != 0 || q_nol.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", q_lim.size(), q_nol.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
